fft_scale_history_tracker: RTL
==============================

# fft_scale_history_tracker

Multi-channel block-floating-point scale tracker for the FFT datapath. Per frame, it accumulates the per-stage rescale shifts reported by the butterfly stages and collects overflow statistics. It records a per-stage shift history for each channel and presents a registered frame summary on a valid/ready result port. It sits beside the stage controller and feeds the CSR block and output normalisation logic.

## Interface
- NUM_CHANNELS, 4, independent frame contexts; history is kept per channel.
- MAX_STAGES, 16, history depth per channel (stages logged per frame).
- SHIFT_WIDTH, 2, width of the per-stage shift amount (0..3 bits per stage).
- SCALE_WIDTH, 8, width of the accumulated scale exponent.
- COUNT_WIDTH, 8, width of the stage counter and the overflow counter.
- MAG_WIDTH, 8, width of the overflow magnitude.
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- frame_start_i  in  1  pulse that begins a frame.
- frame_chan_i  in  $clog2(NUM_CHANNELS)  channel of the frame; sampled with frame_start_i.
- track_en_i  in  1  tracking enable; sampled with frame_start_i.
- stage_valid_i  in  1  stage-complete event.
- stage_shift_i  in  SHIFT_WIDTH  shift applied in that stage.
- stage_ovf_i  in  1  overflow detected in that stage.
- stage_mag_i  in  MAG_WIDTH  overflow magnitude; meaningful when stage_ovf_i=1.
- frame_end_i  in  1  last-stage marker.
- result_valid_o  out  1  frame summary available.
- result_ready_i  in  1  consumer accepts the summary.
- result_chan_o  out  $clog2(NUM_CHANNELS)  channel of the summary.
- result_scale_o  out  SCALE_WIDTH  saturating sum of shifts.
- result_stages_o  out  COUNT_WIDTH  stages counted.
- result_ovf_count_o  out  COUNT_WIDTH  stages with stage_ovf_i=1.
- result_max_mag_o  out  MAG_WIDTH  maximum overflow magnitude.
- result_sat_o  out  1  scale sum saturated during the frame.
- hist_rd_en_i  in  1  history read request.
- hist_rd_chan_i  in  $clog2(NUM_CHANNELS)  read channel.
- hist_rd_stage_i  in  $clog2(MAX_STAGES)  read stage index.
- hist_rd_valid_o  out  1  read data valid.
- hist_rd_shift_o  out  SHIFT_WIDTH  logged shift.
- busy_o  out  1  state is TRACK.
- err_o  out  1  one-cycle protocol-error pulse.

## Operation
- FSM states are IDLE, TRACK and DONE.
- IDLE: frame_start_i with track_en_i=1 clears the accumulators, latches the channel and moves to TRACK. frame_start_i with track_en_i=0 is ignored.
- TRACK, per stage_valid_i:
  - scale += stage_shift_i, saturating at 2^SCALE_WIDTH-1; saturation sets sat (sticky for the frame).
  - stages += 1, saturating.
  - If stage_ovf_i: ovf_count += 1 (saturating), and max_mag = max(max_mag, stage_mag_i).
  - History entry [chan][stages] = stage_shift_i when stages < MAX_STAGES. Otherwise the entry is not written, err_o pulses, and all counters still update.
- frame_end_i in TRACK moves the FSM to DONE. If stage_valid_i is high in the same cycle, that stage is counted first.
- frame_end_i without stage_valid_i closes the frame with no new stage.
- frame_start_i in TRACK aborts the frame: err_o pulses, the accumulators are reinitialised for the new channel, no result is produced, and stale history entries of the aborted channel are retained.
- DONE: result_valid_o=1 with the summary held stable until result_valid_o && result_ready_i. The FSM then returns to IDLE.
- frame_start_i in DONE:
  - Accepted only in the cycle of the result handshake; it then goes directly to TRACK.
  - Otherwise it is ignored and err_o pulses.
- stage_valid_i or frame_end_i in IDLE or DONE is ignored; err_o pulses.
- History reads are independent of the FSM. A read of an entry being written in the same cycle returns the old value.

## Timing
- Reset values: every output is 0, the FSM is in IDLE, and all history entries are 0.
- Accumulator update latency is 1 cycle. result_valid_o rises in the cycle after frame_end_i.
- The minimum frame is frame_start_i at cycle N and frame_end_i at N+1, giving result_valid_o at N+2.
- History read latency is 1 cycle: hist_rd_valid_o and data are valid in the cycle after hist_rd_en_i, for one cycle.
- One stage event is accepted per cycle, back-to-back, with no stall.
- Reset asserted mid-frame returns the block to IDLE and discards the in-flight frame and the pending result.

## Configuration
- FFT_SCALE_HISTORY_EN defined: the history storage of NUM_CHANNELS×MAX_STAGES×SHIFT_WIDTH bits and the read port are built.
- Undefined: no storage is built; hist_rd_valid_o=0 and hist_rd_shift_o=0 constantly.
- Undefined: the stages ≥ MAX_STAGES error is not raised.
- All other behaviour is identical in both builds.

## Test plan
- Channel 2 frame with four stages of shifts 1,0,2,1 and no overflow, then frame_end_i:
  - result: chan=2, scale=4, stages=4, ovf=0, sat=0.
  - history reads of chan 2, stages 0..3 return 1,0,2,1.
- SCALE_WIDTH=8, 130 stages of shift 2 with MAX_STAGES=16:
  - result: scale=255, sat=1, stages=130.
  - err_o pulses on stages 16..129 (first 16 logged).
- Overflows with magnitudes 5,9,3 over three stages: result ovf_count=3, max_mag=9.
- Hold result_ready_i=0 for 5 cycles with frame_start_i pulsed in cycle 2:
  - summary stays stable, err_o pulses once.
  - start plus ready in cycle 5 goes to TRACK with no gap.
- frame_start_i in TRACK (chan 0 to chan 3): err_o pulse, the single result reports chan=3 with only post-restart stages.
- reset_n_i low mid-frame: all outputs 0, and the next frame's result is unaffected by the pre-reset stages.

Source files
------------

// File: rtl/fft_scale_history_tracker.sv
// Block-floating-point scale tracker: per-frame shift/overflow accumulation with a registered
// summary port. Per-channel shift history and its read port exist only with FFT_SCALE_HISTORY_EN.
module fft_scale_history_tracker #(
    parameter int NUM_CHANNELS = 4,
    parameter int MAX_STAGES   = 16,
    parameter int SHIFT_WIDTH  = 2,
    parameter int SCALE_WIDTH  = 8,
    parameter int COUNT_WIDTH  = 8,
    parameter int MAG_WIDTH    = 8
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic                            frame_start_i,
    input  logic [$clog2(NUM_CHANNELS)-1:0] frame_chan_i,
    input  logic                            track_en_i,
    input  logic                            stage_valid_i,
    input  logic [SHIFT_WIDTH-1:0]          stage_shift_i,
    input  logic                            stage_ovf_i,
    input  logic [MAG_WIDTH-1:0]            stage_mag_i,
    input  logic                            frame_end_i,
    output logic                            result_valid_o,
    input  logic                            result_ready_i,
    output logic [$clog2(NUM_CHANNELS)-1:0] result_chan_o,
    output logic [SCALE_WIDTH-1:0]          result_scale_o,
    output logic [COUNT_WIDTH-1:0]          result_stages_o,
    output logic [COUNT_WIDTH-1:0]          result_ovf_count_o,
    output logic [MAG_WIDTH-1:0]            result_max_mag_o,
    output logic                            result_sat_o,
    input  logic                            hist_rd_en_i,
    input  logic [$clog2(NUM_CHANNELS)-1:0] hist_rd_chan_i,
    input  logic [$clog2(MAX_STAGES)-1:0]   hist_rd_stage_i,
    output logic                            hist_rd_valid_o,
    output logic [SHIFT_WIDTH-1:0]          hist_rd_shift_o,
    output logic                            busy_o,
    output logic                            err_o
);
    localparam int CHAN_W  = $clog2(NUM_CHANNELS);
    localparam int STAGE_W = $clog2(MAX_STAGES);
`ifdef FFT_SCALE_HISTORY_EN
    localparam bit HIST_EN = 1'b1;
`else
    localparam bit HIST_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, DONE = 2'd2} state_t;

    state_t                 state_r;
    logic [CHAN_W-1:0]      chan_r;
    logic [SCALE_WIDTH-1:0] scale_r;
    logic [COUNT_WIDTH-1:0] stages_r;
    logic [COUNT_WIDTH-1:0] ovf_count_r;
    logic [MAG_WIDTH-1:0]   max_mag_r;
    logic                   sat_r;
    logic                   err_r;

    logic [SCALE_WIDTH:0]   scale_sum_s;
    logic                   start_s;
    logic                   stage_s;
    logic                   hist_full_s;
    logic                   hist_we_s;
    logic                   err_s;

    // Event decode; a start in TRACK pre-empts any stage seen in the same cycle
    always_comb begin
        scale_sum_s = {1'b0, scale_r} + (SCALE_WIDTH+1)'(stage_shift_i);
        hist_full_s = (stages_r >= COUNT_WIDTH'(MAX_STAGES));
        start_s     = frame_start_i && track_en_i &&
                      ((state_r == IDLE) || (state_r == TRACK) ||
                       ((state_r == DONE) && result_ready_i));
        stage_s     = (state_r == TRACK) && stage_valid_i && !frame_start_i;
        hist_we_s   = stage_s && !hist_full_s;
        err_s       = 1'b0;
        case (state_r)
            IDLE:    err_s = stage_valid_i || frame_end_i;
            TRACK:   err_s = frame_start_i || (stage_s && hist_full_s && HIST_EN);
            DONE:    err_s = stage_valid_i || frame_end_i || (frame_start_i && !result_ready_i);
            default: err_s = 1'b0;
        endcase
    end

    // Frame FSM and summary accumulators
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r     <= IDLE;
            chan_r      <= {CHAN_W{1'b0}};
            scale_r     <= {SCALE_WIDTH{1'b0}};
            stages_r    <= {COUNT_WIDTH{1'b0}};
            ovf_count_r <= {COUNT_WIDTH{1'b0}};
            max_mag_r   <= {MAG_WIDTH{1'b0}};
            sat_r       <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            err_r <= err_s;
            if (start_s) begin
                state_r     <= TRACK;
                chan_r      <= frame_chan_i;
                scale_r     <= {SCALE_WIDTH{1'b0}};
                stages_r    <= {COUNT_WIDTH{1'b0}};
                ovf_count_r <= {COUNT_WIDTH{1'b0}};
                max_mag_r   <= {MAG_WIDTH{1'b0}};
                sat_r       <= 1'b0;
            end else begin
                case (state_r)
                    IDLE:    state_r <= IDLE;
                    // a start without track enable abandons the frame entirely
                    TRACK:   state_r <= frame_start_i ? IDLE : (frame_end_i ? DONE : TRACK);
                    DONE:    state_r <= result_ready_i ? IDLE : DONE;
                    default: state_r <= IDLE;
                endcase
                if (stage_s) begin
                    if (scale_sum_s[SCALE_WIDTH]) begin
                        scale_r <= {SCALE_WIDTH{1'b1}};
                        sat_r   <= 1'b1;
                    end else begin
                        scale_r <= scale_sum_s[SCALE_WIDTH-1:0];
                    end
                    if (stages_r != {COUNT_WIDTH{1'b1}}) begin
                        stages_r <= stages_r + COUNT_WIDTH'(1'b1);
                    end
                    if (stage_ovf_i) begin
                        if (ovf_count_r != {COUNT_WIDTH{1'b1}}) begin
                            ovf_count_r <= ovf_count_r + COUNT_WIDTH'(1'b1);
                        end
                        if (stage_mag_i > max_mag_r) begin
                            max_mag_r <= stage_mag_i;
                        end
                    end
                end
            end
        end
    end

    assign result_valid_o     = (state_r == DONE);
    assign busy_o             = (state_r == TRACK);
    assign result_chan_o      = chan_r;
    assign result_scale_o     = scale_r;
    assign result_stages_o    = stages_r;
    assign result_ovf_count_o = ovf_count_r;
    assign result_max_mag_o   = max_mag_r;
    assign result_sat_o       = sat_r;
    assign err_o              = err_r;

`ifdef FFT_SCALE_HISTORY_EN
    logic [SHIFT_WIDTH-1:0] hist_mem_r [NUM_CHANNELS][MAX_STAGES];
    logic                   rd_valid_r;
    logic [SHIFT_WIDTH-1:0] rd_shift_r;

    // History storage; a same-cycle read sees the pre-write contents
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                for (int s = 0; s < MAX_STAGES; s++) begin
                    hist_mem_r[c][s] <= {SHIFT_WIDTH{1'b0}};
                end
            end
            rd_valid_r <= 1'b0;
            rd_shift_r <= {SHIFT_WIDTH{1'b0}};
        end else begin
            if (hist_we_s) begin
                hist_mem_r[chan_r][stages_r[STAGE_W-1:0]] <= stage_shift_i;
            end
            rd_valid_r <= hist_rd_en_i;
            rd_shift_r <= hist_rd_en_i ? hist_mem_r[hist_rd_chan_i][hist_rd_stage_i]
                                       : {SHIFT_WIDTH{1'b0}};
        end
    end

    assign hist_rd_valid_o = rd_valid_r;
    assign hist_rd_shift_o = rd_shift_r;
`else
    logic unused_hist_s;
    assign unused_hist_s   = ^{hist_rd_en_i, hist_rd_chan_i, hist_rd_stage_i, hist_we_s};
    assign hist_rd_valid_o = 1'b0;
    assign hist_rd_shift_o = {SHIFT_WIDTH{1'b0}};
`endif

endmodule
